// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: keypad lines/controls in, captured code/status out (master drives key/clr/code_ack, slave is the controller)
interface keypad_entry_ctrl_if #(parameter int DIGITS = 4);
  logic [9:0] key;
  logic clr;
  logic code_ack;
  logic [4*DIGITS-1:0] code;
  logic [3:0] digit_cnt;
  logic code_valid;
  logic err;
  logic timeout;
  modport master(output key, clr, code_ack, input code, digit_cnt, code_valid, err, timeout);
  modport slave(input key, clr, code_ack, output code, digit_cnt, code_valid, err, timeout);
endinterface

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounced BCD keypad entry (clk, rst, k.slave: key/clr/code_ack in; code/digit_cnt/code_valid/err/timeout out); KEYPAD_TIMEOUT_EN enables idle timeout
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIGITS = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic rst,
  keypad_entry_ctrl_if.slave k
);
  localparam int W = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, RELEASE, FULL} state_t;
  state_t state, state_n;
  logic [9:0] pat, pat_n;
  logic [7:0] cnt, cnt_n;
  logic [W-1:0] code, code_n;
  logic [3:0] dcnt, dcnt_n, digit;
  logic err, err_n, mprev, single, multi;
  assign single = $onehot(k.key);
  assign multi = |k.key && !single;
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++) if (k.key[i]) digit = 4'(i);
  end
`ifdef KEYPAD_TIMEOUT_EN
  logic [31:0] tmr, tmr_n;
  logic tout, tout_n;
`endif
  always_comb begin
    state_n = state;
    pat_n = pat;
    cnt_n = cnt;
    code_n = code;
    dcnt_n = dcnt;
    unique case (state)
      IDLE: if (single) begin
        state_n = DEBOUNCE;
        pat_n = k.key;
        cnt_n = 8'd1;
      end
      DEBOUNCE: if (k.key != pat) state_n = IDLE;
      else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        code_n = (code << 4) | W'(digit);
        dcnt_n = dcnt + 4'd1;
        cnt_n = 8'd0;
        state_n = RELEASE;
      end else cnt_n = cnt + 8'd1;
      RELEASE: if (k.key == 10'd0) state_n = dcnt == 4'(DIGITS) ? FULL : IDLE;
      FULL: if (k.code_ack) begin
        code_n = '0;
        dcnt_n = 4'd0;
        state_n = IDLE;
      end
    endcase
    // err fires on the first multi-key sample only, so a held chord yields one pulse
    err_n = multi && !mprev && (state == IDLE || state == DEBOUNCE);
`ifdef KEYPAD_TIMEOUT_EN
    tmr_n = 32'd0;
    tout_n = 1'b0;
    if (state == IDLE && k.key == 10'd0 && dcnt != 4'd0) begin
      if (tmr == 32'(TIMEOUT_CYCLES - 1)) begin
        tout_n = 1'b1;
        code_n = '0;
        dcnt_n = 4'd0;
      end else tmr_n = tmr + 32'd1;
    end
`endif
    if (k.clr) begin
      state_n = IDLE;
      code_n = '0;
      dcnt_n = 4'd0;
      cnt_n = 8'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pat <= '0;
      cnt <= '0;
      code <= '0;
      dcnt <= '0;
      err <= 1'b0;
      mprev <= 1'b0;
    end else begin
      state <= state_n;
      pat <= pat_n;
      cnt <= cnt_n;
      code <= code_n;
      dcnt <= dcnt_n;
      err <= err_n;
      mprev <= multi;
    end
  end
`ifdef KEYPAD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
      tout <= 1'b0;
    end else begin
      tmr <= tmr_n;
      tout <= tout_n;
    end
  end
  assign k.timeout = tout;
`else
  assign k.timeout = 1'b0;
`endif
  assign k.code = code;
  assign k.digit_cnt = dcnt;
  assign k.code_valid = state == FULL;
  assign k.err = err;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: scoreboard-driven bench for keypad_entry_ctrl (default 4 digits, 4-cycle debounce, timeout 10)
module tb_keypad_entry_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_bad = 0, n_err = 0, n_to = 0;
  logic [15:0] mcode = '0;
  logic [15:0] exp_q[$];
  logic [3:0] prev_cnt = '0;
  keypad_entry_ctrl_if #(.DIGITS(4)) k();
  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(4), .DIGITS(4), .TIMEOUT_CYCLES(10)) dut (.clk(clk), .rst(rst), .k(k));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && k.digit_cnt > prev_cnt) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL capture: unexpected capture code=%h, none expected", k.code);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (k.code !== e) begin
          n_bad++;
          $display("FAIL capture: code=%h expected %h", k.code, e);
        end
      end
    end
    if (!rst && k.err) n_err++;
    if (!rst && k.timeout) n_to++;
    prev_cnt = k.digit_cnt;
  end
  task automatic press(input int d, input int hold, input bit cap);
    @(negedge clk);
    k.key = 10'b1 << d;
    if (cap) begin
      mcode = {mcode[11:0], 4'(d)};
      exp_q.push_back(mcode);
    end
    repeat (hold) @(negedge clk);
    k.key = '0;
    repeat (2) @(negedge clk);
  endtask
  task automatic do_clr();
    @(negedge clk);
    k.clr = 1'b1;
    @(negedge clk);
    k.clr = 1'b0;
    mcode = '0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    k.key = '0;
    k.clr = 1'b0;
    k.code_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (k.code !== 16'h0) begin n_bad++; $display("FAIL reset_code: %h vs 0", k.code); end
    n_cmp++; if (k.digit_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: %0d vs 0", k.digit_cnt); end
    n_cmp++; if (k.code_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: %b vs 0", k.code_valid); end
    n_cmp++; if ({k.err, k.timeout} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: %b vs 00", {k.err, k.timeout}); end
    rst = 1'b0;
  endtask
  task automatic test_single();
    @(negedge clk);
    k.key = 10'b0000001000;
    mcode = 16'h0003;
    exp_q.push_back(mcode);
    repeat (3) @(negedge clk);
    n_cmp++; if (k.digit_cnt !== 4'd0) begin n_bad++; $display("FAIL latency_early: cnt=%0d vs 0 after 3 edges", k.digit_cnt); end
    @(negedge clk);
    n_cmp++; if (k.digit_cnt !== 4'd1 || k.code[3:0] !== 4'd3) begin n_bad++; $display("FAIL latency_4th: cnt=%0d code=%h vs 1/3", k.digit_cnt, k.code); end
    repeat (2) @(negedge clk);
    k.key = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (k.digit_cnt !== 4'd1) begin n_bad++; $display("FAIL no_double: cnt=%0d vs 1", k.digit_cnt); end
    do_clr();
    n_cmp++; if (k.digit_cnt !== 4'd0 || k.code !== 16'h0) begin n_bad++; $display("FAIL clr: cnt=%0d code=%h vs 0/0", k.digit_cnt, k.code); end
  endtask
  task automatic test_glitch();
    @(negedge clk);
    k.key = 10'b0000000010;
    repeat (2) @(negedge clk);
    k.key = '0;
    repeat (6) @(negedge clk);
    n_cmp++; if (k.digit_cnt !== 4'd0 || k.code !== 16'h0) begin n_bad++; $display("FAIL glitch: cnt=%0d code=%h vs 0/0", k.digit_cnt, k.code); end
  endtask
  task automatic test_full();
    for (int d = 1; d <= 4; d++) press(d, 5, 1'b1);
    n_cmp++; if (k.code !== 16'h1234 || k.code_valid !== 1'b1) begin n_bad++; $display("FAIL full: code=%h valid=%b vs 1234/1", k.code, k.code_valid); end
    press(5, 6, 1'b0);
    repeat (4) @(negedge clk);
    n_cmp++; if (k.code !== 16'h1234 || k.digit_cnt !== 4'd4 || k.code_valid !== 1'b1) begin n_bad++; $display("FAIL full_hold: code=%h cnt=%0d valid=%b vs 1234/4/1", k.code, k.digit_cnt, k.code_valid); end
    k.code_ack = 1'b1;
    @(negedge clk);
    k.code_ack = 1'b0;
    mcode = '0;
    n_cmp++; if (k.code !== 16'h0 || k.digit_cnt !== 4'd0 || k.code_valid !== 1'b0) begin n_bad++; $display("FAIL ack: code=%h cnt=%0d valid=%b vs 0/0/0", k.code, k.digit_cnt, k.code_valid); end
  endtask
  task automatic test_multi();
    int e0;
    e0 = n_err;
    @(negedge clk);
    k.key = 10'b1000000001;
    repeat (5) @(negedge clk);
    k.key = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL multi_err: %0d pulses vs 1", n_err - e0); end
    n_cmp++; if (k.digit_cnt !== 4'd0) begin n_bad++; $display("FAIL multi_nocap: cnt=%0d vs 0", k.digit_cnt); end
  endtask
  task automatic test_clr_ack();
    press(7, 5, 1'b1);
    press(8, 5, 1'b1);
    k.code_ack = 1'b1;
    @(negedge clk);
    k.code_ack = 1'b0;
    n_cmp++; if (k.digit_cnt !== 4'd2 || k.code !== 16'h0078) begin n_bad++; $display("FAIL ack_ignored: cnt=%0d code=%h vs 2/0078", k.digit_cnt, k.code); end
    k.clr = 1'b1;
    k.code_ack = 1'b1;
    @(negedge clk);
    k.clr = 1'b0;
    k.code_ack = 1'b0;
    mcode = '0;
    n_cmp++; if (k.digit_cnt !== 4'd0 || k.code !== 16'h0) begin n_bad++; $display("FAIL clr_ack: cnt=%0d code=%h vs 0/0", k.digit_cnt, k.code); end
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    k.key = 10'b1 << 5;
    mcode = 16'h0005;
    exp_q.push_back(mcode);
    repeat (5) @(negedge clk);
    k.key = 10'b1 << 6;
    repeat (6) @(negedge clk);
    k.key = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (k.digit_cnt !== 4'd1 || k.code !== 16'h0005) begin n_bad++; $display("FAIL b2b: cnt=%0d code=%h vs 1/0005", k.digit_cnt, k.code); end
    do_clr();
  endtask
  task automatic test_rst_mid();
    press(9, 5, 1'b1);
    @(negedge clk);
    k.key = 10'b1 << 2;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    k.key = '0;
    @(negedge clk);
    mcode = '0;
    n_cmp++; if (k.code !== 16'h0 || k.digit_cnt !== 4'd0 || k.code_valid !== 1'b0 || k.err !== 1'b0 || k.timeout !== 1'b0) begin n_bad++; $display("FAIL rst_mid: code=%h cnt=%0d valid=%b err=%b to=%b vs all 0", k.code, k.digit_cnt, k.code_valid, k.err, k.timeout); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_timeout();
    int t0;
    t0 = n_to;
    press(4, 5, 1'b1);
`ifdef KEYPAD_TIMEOUT_EN
    for (int i = 0; i < 20 && n_to == t0; i++) @(negedge clk);
    n_cmp++; if (n_to - t0 !== 1 || k.digit_cnt !== 4'd0) begin n_bad++; $display("FAIL timeout: pulses=%0d cnt=%0d vs 1/0", n_to - t0, k.digit_cnt); end
    mcode = '0;
`else
    repeat (30) @(negedge clk);
    n_cmp++; if (n_to != t0 || k.digit_cnt !== 4'd1) begin n_bad++; $display("FAIL persist: pulses=%0d cnt=%0d vs 0/1", n_to - t0, k.digit_cnt); end
    do_clr();
`endif
  endtask
  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_full();
    test_multi();
    test_clr_ack();
    test_back_to_back();
    test_rst_mid();
    test_timeout();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL pending: %0d expected captures never seen vs 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: number of consecutive sampled cycles a key must be stable before capture; legal range 2..255.
REQ-002 SHALL have parameter DIGITS, default 4: number of BCD digits in a complete entry; legal range 1..8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles before a partial entry is discarded; used only when KEYPAD_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1: the single clock; every register updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port key, input, 10: raw keypad lines; bit i high means key i is pressed.
REQ-007 SHALL have port clr, input, 1: discards the current entry.
REQ-008 SHALL have port code_ack, input, 1: consumer acknowledges a completed code.
REQ-009 SHALL have port code, output, 4*DIGITS: captured BCD digits, most recent digit in bits [3:0].
REQ-010 SHALL have port digit_cnt, output, 4: number of digits captured so far.
REQ-011 SHALL have port code_valid, output, 1: a complete entry is held in code.
REQ-012 SHALL have port err, output, 1: one-cycle pulse flagging a multi-key press.
REQ-013 SHALL have port timeout, output, 1: one-cycle pulse flagging a timeout clear.

Function
REQ-014 SHALL classify key as follows: exactly one bit set is a valid press, with digit equal to the bit index (0..9); all zero is no press; two or more bits set is a multi-key press.
REQ-015 SHALL implement the states IDLE, DEBOUNCE, RELEASE and FULL.
REQ-016 In IDLE, a valid press SHALL latch the key pattern, set the debounce count to 1, and move to DEBOUNCE.
REQ-017 In DEBOUNCE, a sample equal to the latched pattern SHALL increment the count; any differing sample SHALL return to IDLE without capturing.
REQ-018 On the edge that samples the pattern for the DEBOUNCE_CYCLES-th consecutive time, the block SHALL set code = {code[4*DIGITS-5:0], digit}, increment digit_cnt, and move to RELEASE.
REQ-019 The latency from the first sample of a stable key to the code update SHALL be DEBOUNCE_CYCLES edges, inclusive.
REQ-020 In RELEASE, the block SHALL wait for key == 0; it SHALL then move to FULL if digit_cnt == DIGITS, otherwise to IDLE; a held key SHALL never be captured twice.
REQ-021 In FULL, code_valid SHALL be 1 and key SHALL be ignored; code_ack sampled high SHALL clear code and digit_cnt to 0, drop code_valid on the next edge, and move to IDLE.
REQ-022 code_valid SHALL be 1 only in FULL.
REQ-023 code_ack asserted outside FULL SHALL be ignored.
REQ-024 A multi-key press sampled in IDLE or DEBOUNCE SHALL pulse err for one cycle and leave or return the FSM in IDLE; err SHALL stay high for only one cycle even if the multi-key press persists.
REQ-025 clr sampled high in any state SHALL clear code and digit_cnt to 0 and move to IDLE; clr SHALL win over a simultaneous code_ack or capture.
REQ-026 digit_cnt SHALL never exceed DIGITS.

Reset
REQ-027 rst sampled high SHALL force IDLE, with code = 0, digit_cnt = 0, code_valid = 0, err = 0, timeout = 0, and all counters at 0.
REQ-028 rst SHALL take priority over every other input, including when asserted mid-debounce or in FULL.

Configuration
REQ-029 When the macro KEYPAD_TIMEOUT_EN is defined, the block SHALL clear code and digit_cnt and pulse timeout for one cycle after TIMEOUT_CYCLES consecutive cycles in IDLE with key == 0 and digit_cnt > 0.
REQ-030 When KEYPAD_TIMEOUT_EN is defined, any non-zero key SHALL restart the timeout count.
REQ-031 When KEYPAD_TIMEOUT_EN is undefined, timeout SHALL be tied to 0, no timeout counter SHALL exist, and a partial entry SHALL persist indefinitely.

Verification
REQ-032 Defaults: press key = 10'b0000001000 for 6 cycles, then release -> code[3:0] = 3 and digit_cnt = 1 on the 4th edge; no second capture.
REQ-033 Glitch: key = 10'b0000000010 for 2 cycles, then 0 -> digit_cnt stays 0 and code stays 0.
REQ-034 Keys 1, 2, 3, 4, each debounced and released -> code = 16'h1234 and code_valid = 1; code_valid holds until code_ack; one cycle after code_ack, code = 0 and digit_cnt = 0.
REQ-035 key = 10'b1000000001 in IDLE -> exactly one err pulse; no capture.
REQ-036 After 2 digits, assert clr and code_ack together -> code = 0 and digit_cnt = 0.
REQ-037 Assert rst during DEBOUNCE -> all outputs 0 next cycle.
REQ-038 With KEYPAD_TIMEOUT_EN defined and TIMEOUT_CYCLES = 10, leave 1 digit idle for 10 cycles -> timeout pulse and digit_cnt = 0.
